// File: rtl/e203_itcm_ram_ctrl.sv
// ITCM SRAM initiator-side controller: command/response channels to a
// one-cycle-latency single-port RAM, with idle-driven light sleep.
module e203_itcm_ram_ctrl #(
    parameter int DW      = 64,
    parameter int MW      = DW / 8,
    parameter int RAM_AW  = 13,
    parameter int ADDR_W  = 20,
    parameter int LS_IDLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DW-1:0]     cmd_wdata,
    input  logic [MW-1:0]     cmd_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [MW-1:0]     ram_wem,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,
    output logic              ram_sd,
    output logic              ram_ds,
    output logic              ram_ls
);

    localparam int OFS = $clog2(MW);
    localparam int TOP = RAM_AW + OFS;
    localparam int CW  = $clog2(LS_IDLE + 1);
    localparam logic [CW-1:0] LS_MAX  = CW'(LS_IDLE);
    localparam logic [CW-1:0] LS_LAST = CW'(LS_IDLE - 1);

    logic          fire;
    logic          oor;
    logic          idle;
    logic          is_read;
    logic          first;
    logic [DW-1:0] hold;
    logic [CW-1:0] idle_cnt;
    logic          unused_addr;

    generate
        if (ADDR_W > TOP) begin : g_oor
            assign oor = |cmd_addr[ADDR_W-1:TOP];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    assign unused_addr = ^cmd_addr[OFS-1:0];

    assign cmd_ready = !rst & !ram_ls & (!rsp_valid | rsp_ready);
    assign fire      = cmd_valid & cmd_ready;

    assign ram_cs   = fire & !oor;
    assign ram_we   = !cmd_read;
    assign ram_addr = cmd_addr[TOP-1:OFS];
    assign ram_wem  = cmd_read ? '0 : cmd_wmask;
    assign ram_din  = cmd_wdata;
    assign ram_sd   = 1'b0;
    assign ram_ds   = 1'b0;

    // RAM data is only valid in the first response cycle; later stalls replay it
    assign rsp_rdata = (rsp_valid & is_read) ? (first ? ram_dout : hold) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            is_read   <= 1'b0;
            first     <= 1'b0;
            hold      <= '0;
        end else begin
            if (first) begin
                hold <= ram_dout;
            end
            if (fire) begin
                rsp_valid <= 1'b1;
                is_read   <= cmd_read & !oor;
                rsp_err   <= oor;
                first     <= 1'b1;
            end else begin
                first <= 1'b0;
                if (rsp_valid & rsp_ready) begin
                    rsp_valid <= 1'b0;
                end
            end
        end
    end

    assign idle = !cmd_valid & !rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            ram_ls   <= 1'b0;
        end else begin
            if (!idle) begin
                idle_cnt <= '0;
            end else if (idle_cnt != LS_MAX) begin
                idle_cnt <= idle_cnt + CW'(1);
            end
            // any request wakes the RAM; the command is accepted next cycle
            if (ram_ls & cmd_valid) begin
                ram_ls <= 1'b0;
            end else if (idle & (idle_cnt == LS_LAST)) begin
                ram_ls <= 1'b1;
            end
        end
    end

endmodule
